// File: rtl/saddc_tree_walker_if.sv
// saddc_tree_walker_if
// Purpose : request/response handshake bundle for the SADDC decision-tree walker.
//           The front-end (master) issues tagged classification requests, may flush
//           a walk in flight, and consumes the leaf-class response.
// Signals : io_req_valid/io_req_ready/io_req_bits_tag   request handshake and tag
//           io_flush                                      synchronous abort of a walk
//           io_resp_valid/io_resp_ready                   response handshake
//           io_resp_bits_class/tag/depth/err              response payload
//           busy                                          walker is not idle
// Modports: master = request front-end, slave = tree walker
interface saddc_tree_walker_if #(
    parameter int TAG_W   = 4,
    parameter int CLASS_W = 4,
    parameter int NODE_W  = 4
);
    logic               io_req_valid;
    logic               io_req_ready;
    logic [TAG_W-1:0]   io_req_bits_tag;
    logic               io_flush;
    logic               io_resp_valid;
    logic               io_resp_ready;
    logic [CLASS_W-1:0] io_resp_bits_class;
    logic [TAG_W-1:0]   io_resp_bits_tag;
    logic [NODE_W-1:0]  io_resp_bits_depth;
    logic               io_resp_bits_err;
    logic               busy;

    modport master (
        output io_req_valid, io_req_bits_tag, io_flush, io_resp_ready,
        input  io_req_ready, io_resp_valid, io_resp_bits_class, io_resp_bits_tag,
               io_resp_bits_depth, io_resp_bits_err, busy
    );

    modport slave (
        input  io_req_valid, io_req_bits_tag, io_flush, io_resp_ready,
        output io_req_ready, io_resp_valid, io_resp_bits_class, io_resp_bits_tag,
               io_resp_bits_depth, io_resp_bits_err, busy
    );
endinterface

// File: rtl/saddc_tree_walker.sv
// saddc_tree_walker
// Purpose : sequential decision-tree walker for the SADDC classifier. One shared signed
//           <= comparator evaluates one node per step. Each request walks a complete
//           binary tree held in an external node table from the root (node 0) down to a
//           leaf and returns the leaf class on a valid/ready response.
// Ports   : clk, reset_n (async, active-low)
//           io             request/response/flush handshake (saddc_tree_walker_if.slave)
//           node_rd_*      node-table read port, data returned one cycle after the strobe
//           feat_rd_*      feature-memory read port, data returned one cycle after the strobe
module saddc_tree_walker #(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 3,
    parameter  int FSEL_W  = 4,
    parameter  int CLASS_W = 4,
    parameter  int TAG_W   = 4,
    localparam int NODE_W  = DEPTH + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    saddc_tree_walker_if.slave  io,
    output logic                node_rd_en,
    output logic [NODE_W-1:0]   node_rd_addr,
    input  logic                node_rd_leaf,
    input  logic [FSEL_W-1:0]   node_rd_fsel,
    input  logic [DATA_W-1:0]   node_rd_weight,
    input  logic [CLASS_W-1:0]  node_rd_class,
    output logic                feat_rd_en,
    output logic [FSEL_W-1:0]   feat_rd_addr,
    input  logic [DATA_W-1:0]   feat_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_NODE,
        FETCH_FEAT,
        COMPARE,
        RESP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [NODE_W-1:0]   r_nodeIdx;
    logic [NODE_W-1:0]   r_level;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_weight;
    logic [CLASS_W-1:0]  r_class;
    logic                r_err;
    logic                w_atMaxLevel;
    logic                w_goLeft;
    logic                w_reqReady;
    logic                w_respValid;
    logic                w_busy;

    // Deepest legal level holds leaves only; a non-leaf there is a malformed table.
    assign w_atMaxLevel = (r_level == NODE_W'(DEPTH));

    // The single shared comparator: feature <= threshold sends the walk left.
    assign w_goLeft = ($signed(feat_rd_data) <= $signed(r_weight));

    // State register; reset lands in IDLE immediately, even mid-walk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Flush wins over everything outside IDLE, including a
    // response handshake in the same cycle, so the response is simply dropped.
    always_comb begin
        w_nextState = r_state;
        if (r_state != IDLE && io.io_flush) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:       if (io.io_req_valid) w_nextState = FETCH_NODE;
                FETCH_NODE: w_nextState = FETCH_FEAT;
                FETCH_FEAT: begin
                    if (node_rd_leaf || w_atMaxLevel) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = COMPARE;
                    end
                end
                COMPARE:    w_nextState = FETCH_NODE;
                RESP:       if (io.io_resp_ready) w_nextState = IDLE;
                default:    w_nextState = IDLE;
            endcase
        end
    end

    // Output decode. Read strobes are one-cycle pulses tied to their states, and the
    // feature read is only issued when the fetched node will actually be compared.
    always_comb begin
        w_reqReady   = 1'b0;
        w_respValid  = 1'b0;
        w_busy       = 1'b1;
        node_rd_en   = 1'b0;
        node_rd_addr = '0;
        feat_rd_en   = 1'b0;
        feat_rd_addr = '0;
        case (r_state)
            IDLE: begin
                w_reqReady = 1'b1;
                w_busy     = 1'b0;
            end
            FETCH_NODE: begin
                node_rd_en   = 1'b1;
                node_rd_addr = r_nodeIdx;
            end
            FETCH_FEAT: begin
                if (!node_rd_leaf && !w_atMaxLevel) begin
                    feat_rd_en   = 1'b1;
                    feat_rd_addr = node_rd_fsel;
                end
            end
            RESP:    w_respValid = 1'b1;
            default: ;
        endcase
    end

    // Walk datapath. The tag and result registers only change outside RESP, so the
    // response payload stays stable for as long as the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nodeIdx <= '0;
            r_level   <= '0;
            r_tag     <= '0;
            r_weight  <= '0;
            r_class   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io.io_req_valid) begin
                        r_tag     <= io.io_req_bits_tag;
                        r_nodeIdx <= '0;
                        r_level   <= '0;
                        r_class   <= '0;
                        r_err     <= 1'b0;
                    end
                end
                FETCH_FEAT: begin
                    if (node_rd_leaf) begin
                        r_class <= node_rd_class;
                    end else if (w_atMaxLevel) begin
                        r_class <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_weight <= node_rd_weight;
                    end
                end
                COMPARE: begin
                    r_nodeIdx <= (r_nodeIdx << 1) + (w_goLeft ? NODE_W'(1) : NODE_W'(2));
                    r_level   <= r_level + NODE_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign io.io_req_ready       = w_reqReady;
    assign io.io_resp_valid      = w_respValid;
    assign io.busy               = w_busy;
    assign io.io_resp_bits_class = r_class;
    assign io.io_resp_bits_tag   = r_tag;
    assign io.io_resp_bits_depth = r_level;
    assign io.io_resp_bits_err   = r_err;

endmodule

// File: tb/tb_saddc_tree_walker.sv
// tb_saddc_tree_walker
// Purpose : self-checking bench for saddc_tree_walker. Holds the node table and feature
//           memory, a tree-walk model that predicts node/feature reads and the response,
//           a per-cycle compare process, and directed tests with literal expectations.
module tb_saddc_tree_walker;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 3;
    localparam int FSEL_W  = 4;
    localparam int CLASS_W = 4;
    localparam int TAG_W   = 4;
    localparam int NODE_W  = DEPTH + 1;
    localparam int NNODES  = 1 << NODE_W;

    typedef struct {
        logic [CLASS_W-1:0] cls;
        logic [TAG_W-1:0]   tag;
        logic [NODE_W-1:0]  depth;
        logic               err;
    } resp_t;

    logic                clk;
    logic                reset_n;
    logic                node_rd_en;
    logic [NODE_W-1:0]   node_rd_addr;
    logic                node_rd_leaf;
    logic [FSEL_W-1:0]   node_rd_fsel;
    logic [DATA_W-1:0]   node_rd_weight;
    logic [CLASS_W-1:0]  node_rd_class;
    logic                feat_rd_en;
    logic [FSEL_W-1:0]   feat_rd_addr;
    logic [DATA_W-1:0]   feat_rd_data;

    saddc_tree_walker_if #(.TAG_W(TAG_W), .CLASS_W(CLASS_W), .NODE_W(NODE_W)) bus();

    saddc_tree_walker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .FSEL_W(FSEL_W), .CLASS_W(CLASS_W), .TAG_W(TAG_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .io            (bus),
        .node_rd_en    (node_rd_en),
        .node_rd_addr  (node_rd_addr),
        .node_rd_leaf  (node_rd_leaf),
        .node_rd_fsel  (node_rd_fsel),
        .node_rd_weight(node_rd_weight),
        .node_rd_class (node_rd_class),
        .feat_rd_en    (feat_rd_en),
        .feat_rd_addr  (feat_rd_addr),
        .feat_rd_data  (feat_rd_data)
    );

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;
    bit expectBusy  = 0;

    logic               nLeaf   [NNODES];
    logic [FSEL_W-1:0]  nFsel   [NNODES];
    logic [DATA_W-1:0]  nWeight [NNODES];
    logic [CLASS_W-1:0] nClass  [NNODES];
    logic [DATA_W-1:0]  featMem [1 << FSEL_W];

    logic [NODE_W-1:0]  pathQ [$];
    logic [FSEL_W-1:0]  featQ [$];
    resp_t              respQ [$];

    int                 lastLatency;
    logic [CLASS_W-1:0] lastClass;
    logic [TAG_W-1:0]   lastTag;
    logic [NODE_W-1:0]  lastDepth;
    logic               lastErr;
    resp_t              exp;

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Node table and feature memory: registered reads, data one cycle after the strobe.
    always @(posedge clk) begin
        if (node_rd_en) begin
            node_rd_leaf   <= nLeaf[node_rd_addr];
            node_rd_fsel   <= nFsel[node_rd_addr];
            node_rd_weight <= nWeight[node_rd_addr];
            node_rd_class  <= nClass[node_rd_addr];
        end
        if (feat_rd_en) begin
            feat_rd_data <= featMem[feat_rd_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearTree();
        for (int i = 0; i < NNODES; i++) begin
            nLeaf[i]   = 1'b0;
            nFsel[i]   = '0;
            nWeight[i] = '0;
            nClass[i]  = '0;
        end
        for (int i = 0; i < (1 << FSEL_W); i++) featMem[i] = '0;
    endtask

    // Tree-walk model: follow the table from the root, recording every node and feature
    // read the walker must issue and the response it must return.
    task automatic modelWalk(input logic [TAG_W-1:0] tag, output resp_t r);
        int idx = 0;
        r.tag   = tag;
        r.cls   = '0;
        r.err   = 1'b0;
        r.depth = '0;
        for (int lvl = 0; lvl <= DEPTH; lvl++) begin
            pathQ.push_back(idx[NODE_W-1:0]);
            r.depth = lvl[NODE_W-1:0];
            if (nLeaf[idx]) begin
                r.cls = nClass[idx];
                break;
            end
            if (lvl == DEPTH) begin
                r.err = 1'b1;
                break;
            end
            featQ.push_back(nFsel[idx]);
            if ($signed(featMem[nFsel[idx]]) <= $signed(nWeight[idx])) idx = 2 * idx + 1;
            else idx = 2 * idx + 2;
        end
        respQ.push_back(r);
    endtask

    // Present one request in an idle cycle; returns at the first negedge after acceptance.
    task automatic applyStimulus(input logic [TAG_W-1:0] tag, output resp_t r);
        @(negedge clk);
        checkOutput("accept req_ready", bus.io_req_ready, 1'b1);
        modelWalk(tag, r);
        bus.io_req_valid    = 1'b1;
        bus.io_req_bits_tag = tag;
        expectBusy          = 1'b1;
        @(negedge clk);
        bus.io_req_valid    = 1'b0;
    endtask

    // Wait (bounded) for the response, stall the consumer for 'hold' cycles, then accept.
    task automatic waitResponse(input int hold);
        int n = 1;
        while (!bus.io_resp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        lastLatency = n;
        if (!bus.io_resp_valid) begin
            checkOutput("resp timeout", bus.io_resp_valid, 1'b1);
            pathQ.delete();
            featQ.delete();
            respQ.delete();
            bus.io_flush = 1'b1;
            expectBusy   = 1'b0;
            @(negedge clk);
            bus.io_flush = 1'b0;
        end else begin
            lastClass = bus.io_resp_bits_class;
            lastTag   = bus.io_resp_bits_tag;
            lastDepth = bus.io_resp_bits_depth;
            lastErr   = bus.io_resp_bits_err;
            repeat (hold) @(negedge clk);
            bus.io_resp_ready = 1'b1;
            expectBusy        = 1'b0;
            respQ.delete(0);
            @(negedge clk);
            bus.io_resp_ready = 1'b0;
        end
    endtask

    // Per-cycle compare shortly after each rising edge: handshake state, every node and
    // feature read against the model's path, and the response payload while valid.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (checkEn) begin
                checkOutput("busy", bus.busy, expectBusy);
                checkOutput("req_ready", bus.io_req_ready, !expectBusy);
                if (node_rd_en) begin
                    if (pathQ.size() == 0) checkOutput("unexpected node read", node_rd_en, 1'b0);
                    else checkOutput("node_rd_addr", node_rd_addr, pathQ.pop_front());
                end
                if (feat_rd_en) begin
                    if (featQ.size() == 0) checkOutput("unexpected feat read", feat_rd_en, 1'b0);
                    else checkOutput("feat_rd_addr", feat_rd_addr, featQ.pop_front());
                end
                if (bus.io_resp_valid) begin
                    if (respQ.size() == 0) begin
                        checkOutput("unexpected resp", bus.io_resp_valid, 1'b0);
                    end else begin
                        checkOutput("resp class", bus.io_resp_bits_class, respQ[0].cls);
                        checkOutput("resp tag", bus.io_resp_bits_tag, respQ[0].tag);
                        checkOutput("resp depth", bus.io_resp_bits_depth, respQ[0].depth);
                        checkOutput("resp err", bus.io_resp_bits_err, respQ[0].err);
                    end
                end
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, bus.io_req_ready, 1'b1);
        checkOutput({tag, " busy"}, bus.busy, 1'b0);
        checkOutput({tag, " resp_valid"}, bus.io_resp_valid, 1'b0);
        checkOutput({tag, " resp bits"}, {bus.io_resp_bits_class, bus.io_resp_bits_tag,
                    bus.io_resp_bits_depth, bus.io_resp_bits_err}, '0);
        checkOutput({tag, " rd strobes"}, {node_rd_en, feat_rd_en}, 2'b00);
        checkOutput({tag, " rd addrs"}, {node_rd_addr, feat_rd_addr}, '0);
    endtask

    // Root compares feature 1 against its threshold; both children are leaves.
    task automatic signedTree(input logic [DATA_W-1:0] feat, input logic [DATA_W-1:0] weight);
        clearTree();
        nFsel[0]   = 4'd1;
        nWeight[0] = weight;
        featMem[1] = feat;
        nLeaf[1]   = 1'b1;
        nClass[1]  = 4'd1;
        nLeaf[2]   = 1'b1;
        nClass[2]  = 4'd2;
    endtask

    initial begin
        reset_n               = 1'b0;
        bus.io_req_valid      = 1'b0;
        bus.io_req_bits_tag   = '0;
        bus.io_flush          = 1'b0;
        bus.io_resp_ready     = 1'b0;
        clearTree();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Root leaf, class 5, tag 3.
        clearTree();
        nLeaf[0]  = 1'b1;
        nClass[0] = 4'd5;
        applyStimulus(4'h3, exp);
        checkOutput("t1 model class", exp.cls, 4'd5);
        waitResponse(0);
        checkOutput("t1 latency", lastLatency, 3);
        checkOutput("t1 class", lastClass, 4'd5);
        checkOutput("t1 tag", lastTag, 4'd3);
        checkOutput("t1 depth", lastDepth, 4'd0);
        checkOutput("t1 err", lastErr, 1'b0);

        // Features equal to thresholds: always left, path 0,1,3,7; consumer stalls 5 cycles.
        clearTree();
        nFsel[0] = 4'd2;  nWeight[0] = 32'd100;        featMem[2] = 32'd100;
        nFsel[1] = 4'd5;  nWeight[1] = 32'hFFFF_FFF9;  featMem[5] = 32'hFFFF_FFF9;
        nFsel[3] = 4'd7;  nWeight[3] = 32'd0;          featMem[7] = 32'd0;
        nLeaf[7] = 1'b1;  nClass[7]  = 4'd9;
        applyStimulus(4'h6, exp);
        checkOutput("t2 model depth", exp.depth, 4'd3);
        waitResponse(5);
        checkOutput("t2 latency", lastLatency, 12);
        checkOutput("t2 class", lastClass, 4'd9);
        checkOutput("t2 depth", lastDepth, 4'd3);
        checkOutput("t5 idle after accept", bus.io_req_ready, 1'b1);

        // Signed compare: -1 <= 0 goes left.
        signedTree(32'hFFFF_FFFF, 32'h0000_0000);
        applyStimulus(4'h1, exp);
        checkOutput("t3a model class", exp.cls, 4'd1);
        waitResponse(0);
        checkOutput("t3a latency", lastLatency, 6);
        checkOutput("t3a class", lastClass, 4'd1);

        // Signed compare: max positive <= -1 is false, goes right.
        signedTree(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(4'h2, exp);
        checkOutput("t3b model class", exp.cls, 4'd2);
        waitResponse(0);
        checkOutput("t3b class", lastClass, 4'd2);
        checkOutput("t3b depth", lastDepth, 4'd1);

        // Always right to node 14, which is wrongly marked non-leaf.
        clearTree();
        featMem[0] = 32'd10;
        nClass[14] = 4'd7;
        applyStimulus(4'hC, exp);
        checkOutput("t4 model err", exp.err, 1'b1);
        waitResponse(1);
        checkOutput("t4 latency", lastLatency, 12);
        checkOutput("t4 err", lastErr, 1'b1);
        checkOutput("t4 class", lastClass, 4'd0);
        checkOutput("t4 depth", lastDepth, 4'd3);

        // Asynchronous reset while in COMPARE (third cycle after acceptance).
        signedTree(32'd5, 32'd9);
        applyStimulus(4'h4, exp);
        repeat (2) @(negedge clk);
        checkEn = 1'b0;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("midwalk reset");
        pathQ.delete();
        featQ.delete();
        respQ.delete();
        expectBusy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Flush during FETCH_FEAT: walk dropped, no response.
        applyStimulus(4'h5, exp);
        @(negedge clk);
        bus.io_flush = 1'b1;
        expectBusy   = 1'b0;
        pathQ.delete();
        featQ.delete();
        respQ.delete();
        @(negedge clk);
        bus.io_flush = 1'b0;
        checkOutput("flush to idle", bus.busy, 1'b0);
        repeat (4) @(negedge clk);

        // A normal request after reset and flush.
        clearTree();
        nLeaf[0]  = 1'b1;
        nClass[0] = 4'd5;
        applyStimulus(4'hA, exp);
        waitResponse(0);
        checkOutput("t6 latency", lastLatency, 3);
        checkOutput("t6 class", lastClass, 4'd5);
        checkOutput("t6 tag", lastTag, 4'hA);

        repeat (2) @(negedge clk);
        checkOutput("queues drained", pathQ.size() + featQ.size() + respQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
